// File: rtl/seg7_pkg.sv
// Shared types and the common 7-segment glyph table for the display path.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h03, 7'h41,
    7'h0E, 7'h21, 7'h06, 7'h7F
  };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational digit-code to active-low segment decode.
// Zero latency; no flow control.
module seg7_glyph
  import seg7_pkg::*;
(
  input  digit_t i_code,
  output seg_t   o_seg
);

  assign o_seg = GLYPH_TABLE[i_code];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scanner: guard intervals, frame-aligned updates,
// leading-zero blanking and blink. Pin outputs are registered (1 cycle behind scan state).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      lzb_en,
  input  logic                      blink_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_start,
  output logic                      pending
);

  localparam int PW    = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]                  r_presc;
  logic [IDX_W-1:0]               r_idx;
  logic [FW-1:0]                  r_frame_cnt;
  logic                           r_phase;
  logic                           r_pending;
  digit_t [NUM_DIGITS-1:0]        r_act;
  digit_t [NUM_DIGITS-1:0]        r_pend;
  logic [NUM_DIGITS-1:0]          r_act_dp;
  logic [NUM_DIGITS-1:0]          r_pend_dp;
  seg_t                           r_seg;
  logic                           r_dp;
  logic [NUM_DIGITS-1:0]          r_an;

  logic                           w_tc;
  logic                           w_wrap;
  logic                           w_guard;
  digit_t                         w_cur;
  logic                           w_cur_dp;
  logic [NUM_DIGITS-1:0]          w_lz;
  logic                           w_lz_blank;
  logic                           w_dark;
  seg_t                           w_glyph;

  assign w_tc     = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_wrap   = w_tc && (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_guard  = (r_presc < PW'(GUARD));
  assign w_cur    = r_act[r_idx];
  assign w_cur_dp = r_act_dp[r_idx];

  // w_lz[k]: digit k and every digit above it are zero.
  always_comb begin
    w_lz = '0;
    w_lz[NUM_DIGITS-1] = (r_act[NUM_DIGITS-1] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      w_lz[k] = w_lz[k+1] && (r_act[k] == 4'h0);
    end
  end

  assign w_lz_blank = lzb_en && (r_idx != '0) && w_lz[r_idx];
  // A blank code with no decimal point leaves its anode off entirely.
  assign w_dark     = w_guard || (blink_en && r_phase) ||
                      ((w_cur == 4'hF) && !w_cur_dp);

  seg7_glyph u_glyph (
    .i_code (w_cur),
    .o_seg  (w_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
      r_pending   <= 1'b0;
      r_act       <= '1;
      r_pend      <= '1;
      r_act_dp    <= '0;
      r_pend_dp   <= '0;
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b1;
      r_an        <= '1;
    end else begin
      r_presc <= w_tc ? '0 : r_presc + PW'(1);
      if (w_tc) begin
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end

      if (w_wrap) begin
        if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
        if (r_pending) begin
          r_act    <= r_pend;
          r_act_dp <= r_pend_dp;
        end
      end

      // A load on the boundary cycle re-arms pending after the old data moved across.
      if (load) begin
        r_pend    <= digits_in;
        r_pend_dp <= dp_in;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end

      r_seg <= w_lz_blank ? SEG_BLANK : w_glyph;
      r_dp  <= ~w_cur_dp;
      r_an  <= w_dark ? '1 : ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign frame_start = w_wrap;
  assign pending     = r_pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed plus randomized bench for seg7_scan_driver against a cycle-count based reference model.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lzb_en = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycle count since reset release plus display registers.
  int          c;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pending;
  logic [6:0]  glyph [16];
  int          seen_a, seen_5;
  int          r_rand;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .GUARD        (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .lzb_en      (lzb_en),
    .blink_en    (blink_en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic model_reset();
    c = 0;
    m_act = 16'hFFFF;
    m_pend = 16'hFFFF;
    m_act_dp = 4'h0;
    m_pend_dp = 4'h0;
    m_pending = 1'b0;
  endtask

  // One clock: check frame_start/pending mid-cycle, predict the registered pins,
  // advance the model on the edge, then compare the pins just after it.
  task automatic step();
    int idx, presc, phase;
    logic [15:0] hi;
    logic [3:0] d;
    logic dk, lz, dark, bnd;
    logic [6:0] es;
    logic ed;
    logic [3:0] ea;
    @(negedge clk);
    bnd = (c % 16 == 15);
    chk("frame_start", frame_start, bnd);
    chk("pending", pending, m_pending);
    idx   = (c / 4) % 4;
    presc = c % 4;
    phase = (c / 32) % 2;
    hi    = m_act >> (4 * idx);
    d     = hi[3:0];
    dk    = m_act_dp[idx];
    lz    = lzb_en && (idx != 0) && (hi == 16'h0);
    dark  = (presc < 1) || (blink_en && phase == 1) || (d == 4'hF && !dk);
    es    = lz ? 7'h7F : glyph[d];
    ed    = ~dk;
    ea    = dark ? 4'hF : ~(4'b0001 << idx);
    @(posedge clk);
    if (bnd && m_pending) begin
      m_act = m_pend;
      m_act_dp = m_pend_dp;
    end
    if (load) begin
      m_pend = digits_in;
      m_pend_dp = dp_in;
      m_pending = 1'b1;
    end else if (bnd) begin
      m_pending = 1'b0;
    end
    c++;
    #1;
    chk("seg", seg, es);
    chk("dp", dp, ed);
    chk("an", an, ea);
    if (an != 4'hF && seg == 7'h03) seen_a++;
    if (an != 4'hF && seg == 7'h12) seen_5++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 16 && (c % 16) != pos; i++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d;
    dp_in = p;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0000011; glyph[11] = 7'b1000001;
    glyph[12] = 7'b0001110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b1111111;
    model_reset();
    seen_a = 0;
    seen_5 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_an", an, 4'hF);
    chk("rst_frame_start", frame_start, 1'b0);
    chk("rst_pending", pending, 1'b0);
    rst_n = 1'b1;

    // 1: idle scan with blank digits
    run(40);

    // 2: mid-frame load, then watch the next frame
    run_to(6);
    do_load(16'h1234, 4'b0010);
    chk("pending_after_load", pending, 1'b1);
    run_to(0);
    run(20);

    // 3: leading-zero blanking on and off
    lzb_en = 1'b1;
    do_load(16'h0070, 4'b0000);
    run_to(0);
    run(16);
    lzb_en = 1'b0;
    run(16);

    // 4: last load before the boundary wins
    run_to(3);
    do_load(16'hAAAA, 4'b0000);
    run(3);
    do_load(16'h5555, 4'b0000);
    seen_a = 0;
    seen_5 = 0;
    run_to(0);
    run(16);
    chk("no_A_shown", seen_a, 0);
    chk("five_shown", seen_5 != 0, 1'b1);

    // 5: load coincident with frame_start while older data is pending
    run_to(2);
    do_load(16'h1111, 4'b0001);
    run_to(15);
    chk("coincident_fs", frame_start, 1'b1);
    do_load(16'h2222, 4'b0100);
    chk("pending_rearmed", pending, 1'b1);
    run(32);

    // 6: blink, then asynchronous reset mid-frame
    blink_en = 1'b1;
    run(80);
    blink_en = 1'b0;
    run(10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", seg, 7'h7F);
    chk("arst_an", an, 4'hF);
    chk("arst_dp", dp, 1'b1);
    chk("arst_pending", pending, 1'b0);
    chk("arst_frame_start", frame_start, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run(20);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        for (int k = 0; k < 4; k++) begin
          r_rand = $urandom_range(0, 5);
          digits_in[4*k +: 4] = (r_rand < 2) ? 4'h0 : (r_rand == 2) ? 4'hF : 4'($urandom_range(0, 15));
        end
        dp_in = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 40) == 0) lzb_en = ~lzb_en;
      if ($urandom_range(0, 60) == 0) blink_en = ~blink_en;
      step();
    end
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
